dm_access_sequencer: RTL
========================

// Module: dm_access_sequencer
// PURPOSE
// - Sequences every load/store from the memory stage onto the single data bus.
// - Accepts one request at a time and splits accesses that cross a word boundary
//   into two aligned word-bus beats. Produces byte masks for stores.
// - For loads, merges the beats, then aligns and sign/zero-extends by funct3.
// - Flags errors for bad funct3, forbidden misalignment or bus timeout.
//   Sits between the memory-stage control and the data bus.
// PARAMETERS
// - ALLOW_MISALIGNED  1    1: split boundary-crossing accesses; 0: reject them with respErr
// - TIMEOUT_CYCLES    255  cycles a beat may wait for dataBusAck before abort; 0 disables
// PORTS
// - clk               in   1   clock; all state changes on rising edge
// - rstN              in   1   reset, asynchronous, active-low
// - reqValid          in   1   memory stage presents a load/store
// - reqReady          out  1   sequencer idle; request accepted when reqValid&&reqReady
// - reqWrite          in   1   1 store, 0 load
// - reqAddr           in   32  byte address
// - reqWData          in   32  store data, LSB-justified
// - reqFunct3         in   3   loadStoreByteSelect (B/H/W/BU/HU)
// - respValid         out  1   one-cycle pulse: request finished
// - respErr           out  1   qualifies respValid: bad funct3, misaligned-forbidden or timeout
// - respRData         out  32  extended load data, valid with respValid && !reqWrite
// - dataBusAddr       out  32  word-aligned beat address, bits[1:0]=0
// - dataBusWriteData  out  32  byte-lane-positioned store data
// - dataBusWriteMask  out  4   byte enables for store beat
// - dataBusWriteEn    out  1   store beat active
// - dataBusReadEn     out  1   load beat active
// - dataBusReadData   in   32  read word, valid when dataBusAck
// - dataBusAck        in   1   beat completes this cycle
// BEHAVIOUR
// - Reset: state IDLE; reqReady=1; respValid=0, respErr=0, respRData=0;
//   bus enables=0, addr/data/mask=0; timeout counter=0.
// - Reset mid-beat: bus enables drop asynchronously. No response is issued.
// - States: IDLE -> BEAT0 -> (BEAT1) -> RESP -> IDLE.
//   ERR path: IDLE -> RESP with respErr=1 and no bus activity.
// - IDLE: reqReady=1. On accept, latch the request.
//   - offset=addr[1:0], size=1/2/4 bytes.
//   - split = offset+size>4.
//   - funct3 in {3,6,7}, or split && !ALLOW_MISALIGNED: go to RESP with error.
// - Store lane positioning: wd64 = {32'b0,wdata} << 8*offset;
//   mk8 = sizeMask << offset, where sizeMask = 1/3/F.
//   - BEAT0 drives wd64[31:0] and mk8[3:0].
//   - BEAT1 drives wd64[63:32] and mk8[7:4].
//   - Bytes outside the mask are don't-care.
// - Beat addresses: BEAT0 = addr & ~3; BEAT1 = BEAT0 + 4, mod 2^32.
//   0xFFFFFFFC wraps to 0x00000000.
// - Bus outputs are registered and held constant while a beat waits for dataBusAck.
//   On ack: go to BEAT1 if split and in BEAT0, otherwise go to RESP.
// - Load merge: rd64 = {beat1Data, beat0Data}, with beat1Data=0 when not split.
//   Shift right by 8*offset, then extend bits [7:0]/[15:0]/[31:0] per funct3.
// - Latency, zero-wait bus: accept in cycle T; BEAT0 in T+1; respValid in T+2 (split: T+3).
//   Each wait cycle adds 1.
// - RESP: respValid=1 for exactly one cycle; reqReady=0. Next state IDLE.
//   A new request can be accepted the cycle after RESP.
// - Timeout: the counter resets at each beat start and increments each un-acked cycle.
//   At TIMEOUT_CYCLES: drop enables and go to RESP with respErr=1.
//   A split store that already completed BEAT0 is not rolled back.
// - dataBusAck outside a beat is ignored. reqValid during busy is ignored, not queued.
// STRUCTURE
// - Package riscv_pkg: FUNCT3_BYTE/HALFWORD/WORD/BYTE_U/HALFWORD_U constants;
//   seq_state_t enum {IDLE,BEAT0,BEAT1,RESP}.
// - Sub-module dm_load_extend (combinational): rd64, offset and funct3 -> respRData.
// - The FSM, lane/mask generation and timeout counter stay in this module.
// TESTING
// - LW 0x100, ack at T+1 with 0xDEADBEEF
//   -> one read at 0x100; respRData=0xDEADBEEF at T+2; respErr=0.
// - LB and LBU 0x103 with word 0x80112233
//   -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
// - LW 0x102, beats return 0xAABBCCDD @0x100 and 0x11223344 @0x104
//   -> respRData=0x3344AABB, respValid at T+3.
// - SH 0x103 data 0x0000BEEF
//   -> beat 0x100: mask 1000, data[31:24]=EF.
//   -> beat 0x104: mask 0001, data[7:0]=BE.
// - LW 0xFFFFFFFE -> beats at 0xFFFFFFFC then 0x00000000.
//   With ALLOW_MISALIGNED=0, LW 0x101 -> respErr, no bus enable.
// - TIMEOUT_CYCLES=4, ack withheld -> enables drop after 4 cycles, respErr=1.
//   Then assert rstN=0 mid-beat -> enables=0 immediately; reqReady=1 after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store encodings and sequencer state type.
// Also holds small funct3 decode helpers.
package riscv_pkg;

  localparam logic [2:0] FUNCT3_BYTE       = 3'b000;
  localparam logic [2:0] FUNCT3_HALFWORD   = 3'b001;
  localparam logic [2:0] FUNCT3_WORD       = 3'b010;
  localparam logic [2:0] FUNCT3_BYTE_U     = 3'b100;
  localparam logic [2:0] FUNCT3_HALFWORD_U = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } seq_state_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    logic [2:0] s;
    s = 3'd4;
    unique case (1'b1)
      f3[1:0] == 2'b00: s = 3'd1;
      f3[1:0] == 2'b01: s = 3'd2;
      default:          s = 3'd4;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    logic [3:0] m;
    m = 4'hF;
    unique case (1'b1)
      f3[1:0] == 2'b00: m = 4'h1;
      f3[1:0] == 2'b01: m = 4'h3;
      default:          m = 4'hF;
    endcase
    return m;
  endfunction

  function automatic logic funct3_bad(input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/dm_load_extend.sv
// Load data alignment: shifts merged beats down by the byte
// offset and sign/zero-extends according to funct3.
module dm_load_extend
  import riscv_pkg::*;
(
  input  logic [63:0] i_rd64,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata
);

  logic [63:0] w_sh;
  logic        w_unused;

  assign w_sh     = i_rd64 >> {i_offset, 3'b000};
  assign w_unused = ^w_sh[63:32];

  always_comb begin
    o_rdata = '0;
    unique case (1'b1)
      i_funct3 == FUNCT3_BYTE:
        o_rdata = {{24{w_sh[7]}}, w_sh[7:0]};
      i_funct3 == FUNCT3_HALFWORD:
        o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
      i_funct3 == FUNCT3_WORD:
        o_rdata = w_sh[31:0];
      i_funct3 == FUNCT3_BYTE_U:
        o_rdata = {24'b0, w_sh[7:0]};
      i_funct3 == FUNCT3_HALFWORD_U:
        o_rdata = {16'b0, w_sh[15:0]};
      default:
        o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/dm_access_sequencer.sv
// Data-memory access sequencer: one request at a time, split into
// one or two aligned word beats on the data bus.
module dm_access_sequencer
  import riscv_pkg::*;
#(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  input  logic [2:0]  reqFunct3,
  output logic        respValid,
  output logic        respErr,
  output logic [31:0] respRData,
  output logic [31:0] dataBusAddr,
  output logic [31:0] dataBusWriteData,
  output logic [3:0]  dataBusWriteMask,
  output logic        dataBusWriteEn,
  output logic        dataBusReadEn,
  input  logic [31:0] dataBusReadData,
  input  logic        dataBusAck
);

  seq_state_t r_state;
  seq_state_t w_stateNx;

  logic        r_write;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic        r_split;
  logic [63:0] r_wd64;
  logic [7:0]  r_mk8;
  logic [31:0] r_beat0Data;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_cnt;
  logic [31:0] r_busAddr;
  logic [31:0] r_busWData;
  logic [3:0]  r_busMask;
  logic        r_busWe;
  logic        r_busRe;

  logic [1:0]  w_off;
  logic [2:0]  w_size;
  logic        w_split;
  logic        w_bad;
  logic [63:0] w_wd64;
  logic [7:0]  w_mk8;
  logic [63:0] w_rd64;
  logic [31:0] w_ext;
  logic [31:0] w_cntInc;
  logic        w_tout;
  logic        w_inBeat;

  logic w_accept;
  logic w_ldBeat0;
  logic w_ldBeat1;
  logic w_finish;
  logic w_abort;
  logic w_reject;

  assign w_off    = reqAddr[1:0];
  assign w_size   = size_bytes(reqFunct3);
  assign w_split  = ({1'b0, w_off} + w_size) > 3'd4;
  assign w_bad    = funct3_bad(reqFunct3)
                  || (w_split && !ALLOW_MISALIGNED);
  assign w_wd64   = {32'b0, reqWData} << {w_off, 3'b000};
  assign w_mk8    = {4'b0, size_mask(reqFunct3)} << w_off;

  assign w_inBeat = (r_state == BEAT0) || (r_state == BEAT1);
  assign w_cntInc = r_cnt + 32'd1;
  assign w_tout   = (TIMEOUT_CYCLES != 0)
                  && (w_cntInc == TIMEOUT_CYCLES);

  // Second beat arrives on top of the first in the merged word.
  assign w_rd64 = (r_state == BEAT1)
                ? {dataBusReadData, r_beat0Data}
                : {32'b0, dataBusReadData};

  dm_load_extend u_ext (
    .i_rd64   (w_rd64),
    .i_offset (r_off),
    .i_funct3 (r_funct3),
    .o_rdata  (w_ext)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_stateNx;
  end

  always_comb begin
    w_stateNx = r_state;
    w_accept  = 1'b0;
    w_ldBeat0 = 1'b0;
    w_ldBeat1 = 1'b0;
    w_finish  = 1'b0;
    w_abort   = 1'b0;
    w_reject  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (reqValid) begin
          w_accept = 1'b1;
          if (w_bad) begin
            w_stateNx = RESP;
            w_reject  = 1'b1;
          end else begin
            w_stateNx = BEAT0;
            w_ldBeat0 = 1'b1;
          end
        end
      end
      BEAT0, BEAT1: begin
        if (dataBusAck) begin
          if (r_state == BEAT0 && r_split) begin
            w_stateNx = BEAT1;
            w_ldBeat1 = 1'b1;
          end else begin
            w_stateNx = RESP;
            w_finish  = 1'b1;
          end
        end else if (w_tout) begin
          w_stateNx = RESP;
          w_abort   = 1'b1;
        end
      end
      RESP:    w_stateNx = IDLE;
      default: w_stateNx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_write     <= 1'b0;
      r_off       <= '0;
      r_funct3    <= '0;
      r_split     <= 1'b0;
      r_wd64      <= '0;
      r_mk8       <= '0;
      r_beat0Data <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_cnt       <= '0;
      r_busAddr   <= '0;
      r_busWData  <= '0;
      r_busMask   <= '0;
      r_busWe     <= 1'b0;
      r_busRe     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= reqWrite;
        r_off    <= w_off;
        r_funct3 <= reqFunct3;
        r_split  <= w_split;
        r_wd64   <= w_wd64;
        r_mk8    <= w_mk8;
      end
      if (w_ldBeat0) begin
        r_busAddr  <= {reqAddr[31:2], 2'b00};
        r_busWData <= w_wd64[31:0];
        r_busMask  <= reqWrite ? w_mk8[3:0] : 4'b0;
        r_busWe    <= reqWrite;
        r_busRe    <= !reqWrite;
        r_cnt      <= '0;
      end
      if (w_ldBeat1) begin
        r_beat0Data <= dataBusReadData;
        r_busAddr   <= r_busAddr + 32'd4;
        r_busWData  <= r_wd64[63:32];
        r_busMask   <= r_write ? r_mk8[7:4] : 4'b0;
        r_cnt       <= '0;
      end else if (w_inBeat && !dataBusAck) begin
        r_cnt <= w_cntInc;
      end
      if (w_finish || w_abort || w_reject) begin
        r_busWe <= 1'b0;
        r_busRe <= 1'b0;
        r_err   <= w_abort || w_reject;
        r_rdata <= (w_finish && !r_write) ? w_ext : 32'b0;
      end
    end
  end

  assign reqReady         = (r_state == IDLE);
  assign respValid        = (r_state == RESP);
  assign respErr          = respValid && r_err;
  assign respRData        = r_rdata;
  assign dataBusAddr      = r_busAddr;
  assign dataBusWriteData = r_busWData;
  assign dataBusWriteMask = r_busMask;
  assign dataBusWriteEn   = r_busWe;
  assign dataBusReadEn    = r_busRe;

endmodule
